// File: rtl/div_pkg.sv
// div_pkg: shared types for the divider issue sequencer
package div_pkg;
  localparam int DIV_XLEN = 32;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;
  typedef struct packed {
    logic valid;
    logic sign;
    logic [DIV_XLEN-1:0] rs1, rs2, q, r;
  } cache_entry_t;
endpackage

// File: rtl/div_result_cache.sv
// div_result_cache: one-entry store of the last divider result, keyed by operands and signedness
module div_result_cache
  import div_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                we,
  input  logic                w_sign,
  input  logic [DIV_XLEN-1:0] w_rs1,
  input  logic [DIV_XLEN-1:0] w_rs2,
  input  logic [DIV_XLEN-1:0] w_q,
  input  logic [DIV_XLEN-1:0] w_r,
  input  logic                l_sign,
  input  logic [DIV_XLEN-1:0] l_rs1,
  input  logic [DIV_XLEN-1:0] l_rs2,
  output logic                hit,
  output logic [DIV_XLEN-1:0] q,
  output logic [DIV_XLEN-1:0] r
);
  cache_entry_t e;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) e <= '0;
    else if (we) e <= '{valid: 1'b1, sign: w_sign, rs1: w_rs1, rs2: w_rs2, q: w_q, r: w_r};
  assign hit = e.valid && e.sign == l_sign && e.rs1 == l_rs1 && e.rs2 == l_rs2;
  assign q = e.q;
  assign r = e.r;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: issues DIV/REM requests to the iterative divider and returns results to writeback
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            stall_i,
  input  logic            kill_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic [RD_W-1:0] rsp_rd_o,
  output logic            busy_o,
  output logic            div_start_o,
  output logic            div_sign_o,
  output logic            div_stall_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i,
  input  logic            div_valid_i
);
  state_e          state;
  logic            armed, sign_q, want_rem_q, hit, capture;
  logic [XLEN-1:0] rs1_q, rs2_q, rsp_data_q, c_q, c_r;
  logic [RD_W-1:0] rd_q;
  assign capture = state == S_RUN && armed && div_valid_i && !stall_i && !kill_i;
  div_result_cache u_cache (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .we      (capture),
    .w_sign  (sign_q),
    .w_rs1   (rs1_q),
    .w_rs2   (rs2_q),
    .w_q     (div_quotient_i),
    .w_r     (div_remainder_i),
    .l_sign  (~op_i[0]),
    .l_rs1   (rs1_i),
    .l_rs2   (rs2_i),
    .hit     (hit),
    .q       (c_q),
    .r       (c_r)
  );
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      sign_q     <= 1'b0;
      want_rem_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
    end else if (kill_i) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        S_IDLE: if (req_valid_i) begin
          sign_q     <= ~op_i[0];
          want_rem_q <= op_i[1];
          rs1_q      <= rs1_i;
          rs2_q      <= rs2_i;
          rd_q       <= rd_i;
          if (hit) rsp_data_q <= op_i[1] ? c_r : c_q;
          state <= hit ? S_RESP : S_RUN;
        end
        // a valid seen before armed is the divider's stale idle strobe
        S_RUN: begin
          armed <= !capture;
          if (capture) begin
            rsp_data_q <= want_rem_q ? div_remainder_i : div_quotient_i;
            state      <= S_RESP;
          end
        end
        S_RESP: if (rsp_ready_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  assign req_ready_o    = reset_ni && state == S_IDLE && !stall_i && !kill_i;
  assign rsp_valid_o    = state == S_RESP;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_rd_o       = rd_q;
  assign busy_o         = state != S_IDLE;
  assign div_start_o    = state == S_RUN;
  assign div_sign_o     = sign_q;
  assign div_stall_o    = stall_i && reset_ni;
  assign div_dividend_o = rs1_q;
  assign div_divisor_o  = rs2_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of div_sequencer against a behavioural iterative divider
module tb_div_sequencer;
  import div_pkg::*;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
  logic clk_i = 0, reset_ni = 0, stall_i = 0, kill_i = 0, req_valid_i = 0, rsp_ready_i = 0;
  logic [1:0] op_i = 0;
  logic [XLEN-1:0] rs1_i = 0, rs2_i = 0;
  logic [RD_W-1:0] rd_i = 0;
  logic req_ready_o, rsp_valid_o, busy_o, div_start_o, div_sign_o, div_stall_o, div_valid_i;
  logic [XLEN-1:0] rsp_data_o, div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;
  logic [RD_W-1:0] rsp_rd_o;
  int compared = 0, mismatched = 0, cyc = 0, starts = 0, handshakes = 0;
  always #5 clk_i = ~clk_i;
  div_sequencer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .stall_i(stall_i), .kill_i(kill_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rd_i(rd_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .busy_o(busy_o), .div_start_o(div_start_o),
    .div_sign_o(div_sign_o), .div_stall_o(div_stall_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_quotient_i(div_quotient_i),
    .div_remainder_i(div_remainder_i), .div_valid_i(div_valid_i)
  );
  logic m_run, m_done;
  int m_cnt;
  logic [XLEN-1:0] m_q, m_r;
  assign div_valid_i = m_done;
  assign div_quotient_i = m_q;
  assign div_remainder_i = m_r;
  function automatic int iters(input logic [XLEN-1:0] a, input logic s);
    logic [XLEN-1:0] m = (s && a[XLEN-1]) ? -a : a;
    int n = 3;
    for (int i = 0; i < XLEN; i++) if (m[i] && i + 1 > n) n = i + 1;
    return n;
  endfunction
  // loads one edge after start rises, strobes valid N edges later, clears when start drops
  always @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      m_run <= 0; m_done <= 0; m_cnt <= 0; m_q <= 0; m_r <= 0;
    end else if (!div_stall_o) begin
      if (!div_start_o) begin
        m_run <= 0; m_done <= 0;
      end else if (!m_run && !m_done) begin
        m_run <= 1;
        m_cnt <= iters(div_dividend_o, div_sign_o);
        if (div_divisor_o == 0) begin
          m_q <= '1; m_r <= div_dividend_o;
        end else if (div_sign_o && div_dividend_o == 32'h8000_0000 && div_divisor_o == '1) begin
          m_q <= 32'h8000_0000; m_r <= 0;
        end else if (div_sign_o) begin
          m_q <= $signed(div_dividend_o) / $signed(div_divisor_o);
          m_r <= $signed(div_dividend_o) % $signed(div_divisor_o);
        end else begin
          m_q <= div_dividend_o / div_divisor_o;
          m_r <= div_dividend_o % div_divisor_o;
        end
      end else if (m_run) begin
        if (m_cnt == 1) begin m_run <= 0; m_done <= 1; end
        m_cnt <= m_cnt - 1;
      end
    end
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (div_start_o) starts <= starts + 1;
    if (rsp_valid_o && rsp_ready_i && !stall_i && !kill_i) handshakes <= handshakes + 1;
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RD_W-1:0] rd, output int t_acc);
    int w = 0;
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; req_valid_i = 1;
    while (!req_ready_o && w < 50) begin step(); w++; end
    step();
    req_valid_i = 0;
    t_acc = cyc;
  endtask
  // latency: clock edges after the accept edge until rsp_valid_o is seen; -1 on timeout
  task automatic wait_rsp(input int t_acc, output int lat);
    int w = 0;
    while (!rsp_valid_o && w < 200) begin step(); w++; end
    lat = rsp_valid_o ? cyc - t_acc : -1;
  endtask
  task automatic take();
    rsp_ready_i = 1;
    step();
    rsp_ready_i = 0;
  endtask
  task automatic test_reset();
    stall_i = 1;
    #3;
    compared++; if ({req_ready_o, rsp_valid_o, busy_o, div_start_o, div_sign_o, div_stall_o, rsp_data_o, rsp_rd_o, div_dividend_o, div_divisor_o} !== '0) begin mismatched++; $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b start=%b stall=%b data=%h want all 0", req_ready_o, rsp_valid_o, busy_o, div_start_o, div_stall_o, rsp_data_o); end
    #10;
    reset_ni = 1; stall_i = 0;
    step();
    compared++; if ({req_ready_o, busy_o} !== 2'b10) begin mismatched++; $display("FAIL reset_idle: got ready=%b busy=%b want ready=1 busy=0", req_ready_o, busy_o); end
  endtask
  task automatic test_unsigned_cache();
    int t, lat, s0;
    issue(OP_DIVU, 100, 7, 5, t); wait_rsp(t, lat);
    compared++; if (lat !== 9) begin mismatched++; $display("FAIL divu_lat: got %0d want 9", lat); end
    compared++; if ({rsp_data_o, rsp_rd_o} !== {32'd14, 5'd5}) begin mismatched++; $display("FAIL divu_data: got %h/%0d want 0000000e/5", rsp_data_o, rsp_rd_o); end
    take();
    s0 = starts;
    issue(OP_REMU, 100, 7, 6, t); wait_rsp(t, lat);
    compared++; if (lat !== 0) begin mismatched++; $display("FAIL remu_hit_lat: got %0d want 0", lat); end
    compared++; if ({rsp_data_o, rsp_rd_o} !== {32'd2, 5'd6}) begin mismatched++; $display("FAIL remu_hit_data: got %h/%0d want 00000002/6", rsp_data_o, rsp_rd_o); end
    take();
    compared++; if (starts !== s0) begin mismatched++; $display("FAIL remu_hit_start: got %0d start cycles want 0", starts - s0); end
  endtask
  task automatic test_signed();
    int t, lat;
    issue(OP_DIV, 32'hFFFF_FFEC, 3, 1, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd7, 32'hFFFF_FFFA}) begin mismatched++; $display("FAIL div_neg: got lat=%0d data=%h want lat=7 data=fffffffa", lat, rsp_data_o); end
    take();
    issue(OP_REM, 32'hFFFF_FFEC, 3, 2, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd0, 32'hFFFF_FFFE}) begin mismatched++; $display("FAIL rem_neg_hit: got lat=%0d data=%h want lat=0 data=fffffffe", lat, rsp_data_o); end
    take();
    issue(OP_DIVU, 32'hFFFF_FFEC, 3, 3, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd34, 32'h5555_554E}) begin mismatched++; $display("FAIL divu_sign_miss: got lat=%0d data=%h want lat=34 data=5555554e", lat, rsp_data_o); end
    take();
  endtask
  task automatic test_special();
    int t, lat;
    issue(OP_DIVU, 32'h8000_0000, 0, 1, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd34, 32'hFFFF_FFFF}) begin mismatched++; $display("FAIL divu_by0: got lat=%0d data=%h want lat=34 data=ffffffff", lat, rsp_data_o); end
    take();
    issue(OP_REMU, 32'h1234_5678, 0, 2, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd31, 32'h1234_5678}) begin mismatched++; $display("FAIL remu_by0: got lat=%0d data=%h want lat=31 data=12345678", lat, rsp_data_o); end
    take();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd34, 32'h8000_0000}) begin mismatched++; $display("FAIL div_ovf: got lat=%0d data=%h want lat=34 data=80000000", lat, rsp_data_o); end
    take();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd0, 32'd0}) begin mismatched++; $display("FAIL rem_ovf_hit: got lat=%0d data=%h want lat=0 data=00000000", lat, rsp_data_o); end
    take();
  endtask
  task automatic test_kill();
    int t, lat, s0, seen = 0;
    issue(OP_DIV, 1000, 3, 7, t);
    step(3);
    kill_i = 1;
    step();
    kill_i = 0;
    compared++; if ({busy_o, rsp_valid_o, div_start_o} !== 3'b000) begin mismatched++; $display("FAIL kill_run: got busy=%b valid=%b start=%b want 000", busy_o, rsp_valid_o, div_start_o); end
    repeat (40) begin if (rsp_valid_o) seen++; step(); end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL kill_no_rsp: got %0d valid cycles want 0", seen); end
    s0 = starts;
    issue(OP_DIV, 1000, 3, 8, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd12, 32'd333} || starts == s0) begin mismatched++; $display("FAIL kill_then_miss: got lat=%0d data=%h starts=%0d want lat=12 data=0000014d starts>0", lat, rsp_data_o, starts - s0); end
    take();
  endtask
  task automatic test_stall();
    int t, lat, h0;
    issue(OP_DIVU, 200, 9, 10, t);
    step(3);
    stall_i = 1;
    #1;
    compared++; if ({div_stall_o, req_ready_o, div_start_o} !== 3'b101) begin mismatched++; $display("FAIL stall_run_ctl: got stall=%b ready=%b start=%b want 101", div_stall_o, req_ready_o, div_start_o); end
    step(5);
    stall_i = 0;
    wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd15, 32'd22}) begin mismatched++; $display("FAIL stall_run_lat: got lat=%0d data=%h want lat=15 data=00000016", lat, rsp_data_o); end
    h0 = handshakes;
    stall_i = 1; rsp_ready_i = 1;
    step(3);
    compared++; if ({rsp_valid_o, rsp_data_o} !== {1'b1, 32'd22}) begin mismatched++; $display("FAIL stall_resp_hold: got valid=%b data=%h want valid=1 data=00000016", rsp_valid_o, rsp_data_o); end
    stall_i = 0;
    step();
    rsp_ready_i = 0;
    compared++; if ({handshakes - h0, 31'd0, rsp_valid_o} !== {32'd1, 32'd0}) begin mismatched++; $display("FAIL stall_resp_once: got handshakes=%0d valid=%b want 1/0", handshakes - h0, rsp_valid_o); end
  endtask
  task automatic test_backpressure();
    int t, lat, bad = 0;
    issue(OP_DIV, 77, 5, 9, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd9, 32'd15}) begin mismatched++; $display("FAIL bp_result: got lat=%0d data=%h want lat=9 data=0000000f", lat, rsp_data_o); end
    req_valid_i = 1; op_i = OP_DIVU; rs1_i = 55;
    repeat (4) begin
      step();
      if (rsp_data_o !== 32'd15 || rsp_rd_o !== 5'd9 || req_ready_o || !rsp_valid_o) bad++;
    end
    req_valid_i = 0;
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    take();
    compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL bp_release: got busy=%b want 0", busy_o); end
  endtask
  task automatic test_reset_mid();
    int t, lat;
    issue(OP_DIVU, 5000, 7, 3, t);
    step(3);
    reset_ni = 0;
    #1;
    compared++; if ({req_ready_o, rsp_valid_o, busy_o, div_start_o, div_sign_o, div_stall_o, rsp_data_o, rsp_rd_o, div_dividend_o, div_divisor_o} !== '0) begin mismatched++; $display("FAIL reset_mid_outputs: got busy=%b start=%b dividend=%h data=%h want all 0", busy_o, div_start_o, div_dividend_o, rsp_data_o); end
    step();
    reset_ni = 1;
    step();
    issue(OP_REM, 77, 5, 4, t); wait_rsp(t, lat);
    compared++; if ({lat, rsp_data_o} !== {32'd9, 32'd2}) begin mismatched++; $display("FAIL reset_cache_cleared: got lat=%0d data=%h want lat=9 data=00000002", lat, rsp_data_o); end
    take();
  endtask
  initial begin
    test_reset();
    test_unsigned_cache();
    test_signed();
    test_special();
    test_kill();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
